id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 16-bit, 16-register pipelined CPU. Captures decoded operands, register specifiers and control bits from ID each cycle and presents them to EX and the EX-stage forwarding logic. Detects load-use dependences that forwarding cannot cover, stalls PC and IF/ID, and inserts a bubble. Also supports a global freeze from the memory side and a flush from branch resolution.

## Interface
- DATA_W, 16, datapath width
- REG_W, 4, register specifier width
- ALUOP_W, 4, ALU opcode width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  global pipeline hold, e.g. memory busy
- flush  in  1  taken branch/jump resolved; kill the ID instruction
- IF_ID_Rs, IF_ID_Rt, IF_ID_Rd  in  REG_W  decoded specifiers
- IF_ID_uses_rs, IF_ID_uses_rt  in  1  operand actually read by the instruction
- IF_ID_is_store  in  1  instruction is a store; Rt is store data
- IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_MemtoReg, IF_ID_ALUSrc  in  1  decoded control
- IF_ID_ALUOp  in  ALUOP_W  ALU operation
- IF_ID_rd1, IF_ID_rd2, IF_ID_imm, IF_ID_pc2  in  DATA_W  register reads, sign-extended immediate, PC+2
- ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  out  REG_W  registered specifiers
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc  out  1  registered control
- ID_EX_ALUOp  out  ALUOP_W
- ID_EX_rd1, ID_EX_rd2, ID_EX_imm, ID_EX_pc2  out  DATA_W
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt  out  16  saturating count of inserted load-use bubbles

## Operation
- Hazard: hz = ID_EX_MemRead && (ID_EX_Rd != 0) && ((IF_ID_uses_rs && ID_EX_Rd == IF_ID_Rs) || (IF_ID_uses_rt && !IF_ID_is_store && ID_EX_Rd == IF_ID_Rt)).
- A store's data operand (Rt) is exempt; MEM-to-MEM forwarding covers it. A store's base (Rs) is not exempt.
- R0 is hard-wired zero and never causes a hazard.
- stall = hz && !flush && !freeze. A flushed instruction never stalls.
- Register update priority, evaluated at each rising clk:
  1. rst: clear everything.
  2. freeze: hold every field.
  3. flush: load a bubble.
  4. hz: load a bubble and increment bubble_cnt.
  5. Otherwise: load all IF_ID_* fields.
- Bubble: RegWrite, MemRead and MemWrite are cleared. MemtoReg and ALUSrc are cleared. ALUOp is cleared. Rs, Rt and Rd are cleared to 0. Data fields are don't-care; the implementation clears them to 0.
- bubble_cnt saturates at 16'hFFFF. It is not incremented on flush or freeze bubbles.
- Only one hazard stall per load-use pair. On the next cycle the load has moved to EX/MEM and ID_EX_MemRead is 0, so stall drops.

## Timing
- Reset (synchronous): all ID_EX_* outputs are 0. bubble_cnt is 0. stall reads 0 because ID_EX_MemRead is 0.
- Latency: IF_ID_* inputs appear on ID_EX_* one cycle after capture.
- stall is combinational from registered ID_EX_* state and current IF_ID_* inputs; it is valid in the same cycle.
- freeze during a hazard: stall is 0 and all state is held. The hazard re-evaluates when freeze drops.
- flush and hz together: the flush bubble wins, stall=0, and bubble_cnt is unchanged.
- rst asserted mid-operation takes effect at the next edge regardless of freeze or flush.

## Structure
- Shared package: DATA_W, REG_W, ALUOP_W constants, plus a ctrl bundle typedef (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp) and a CTRL_NOP constant for bubble insertion.
- One sub-module: load_use_detect, a purely combinational block computing hz. The pipeline register and counter live in id_ex_stage.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs -> all outputs 0, stall=0, bubble_cnt=0.
- Load-use: LW R3 followed by ADD R5,R3,R4 -> stall=1 for exactly one cycle, ID_EX control all 0 next cycle, bubble_cnt=1, then ADD is captured.
- Store exemption: LW R3 followed by SW R3,[R6] -> stall=0, and SW is captured directly. LW R3 followed by SW R7,[R3] -> stall=1.
- R0 and unused operands: LW R0 followed by ADD R1,R0,R0 -> no stall. LW R2 followed by an instruction with uses_rt=0 and Rt=2 -> no stall.
- Flush priority: hazard condition with flush=1 -> stall=0, bubble loaded, bubble_cnt unchanged.
- Freeze: freeze=1 for 3 cycles with changing inputs -> ID_EX_* are held. With a pending hazard, stall=0 while frozen and stall=1 on the first unfrozen cycle.
- Saturation: force 65536 load-use bubbles -> bubble_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control bundle and bubble constants for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 16;

  // Decoded control bits carried down the pipe.
  typedef struct packed {
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOp;
  } ctrl_t;

  // Control word of an inserted bubble: no write-back, no memory access.
  localparam ctrl_t CTRL_NOP = '{
    RegWrite: 1'b0,
    MemRead:  1'b0,
    MemWrite: 1'b0,
    MemtoReg: 1'b0,
    ALUSrc:   1'b0,
    ALUOp:    '0
  };

  // Full contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc2;
  } id_ex_t;

  // Bubble: specifiers point at R0 so no forwarding path ever matches it.
  localparam id_ex_t ID_EX_BUBBLE = '{
    rs:   '0,
    rt:   '0,
    rd:   '0,
    ctrl: CTRL_NOP,
    rd1:  '0,
    rd2:  '0,
    imm:  '0,
    pc2:  '0
  };

  // Source of the next ID/EX contents, in decreasing priority below reset.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_FLUSH,
    UPD_HAZARD,
    UPD_LOAD
  } upd_e;

  // Saturating increment for the bubble counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is read as an ALU operand by the instruction in ID.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_store,
  output logic             hz
);

  logic rs_dep;
  logic rt_dep;

  // Store data (Rt) is forwarded MEM-to-MEM, so only the base counts for stores.
  always_comb begin
    rs_dep = id_uses_rs && (ex_rd == id_rs);
    rt_dep = id_uses_rt && !id_is_store && (ex_rd == id_rt);
    hz     = ex_mem_read && (ex_rd != '0) && (rs_dep || rt_dep);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion,
// freeze/flush handling and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic [REG_W-1:0]   IF_ID_Rs,
  input  logic [REG_W-1:0]   IF_ID_Rt,
  input  logic [REG_W-1:0]   IF_ID_Rd,
  input  logic               IF_ID_uses_rs,
  input  logic               IF_ID_uses_rt,
  input  logic               IF_ID_is_store,
  input  logic               IF_ID_RegWrite,
  input  logic               IF_ID_MemRead,
  input  logic               IF_ID_MemWrite,
  input  logic               IF_ID_MemtoReg,
  input  logic               IF_ID_ALUSrc,
  input  logic [ALUOP_W-1:0] IF_ID_ALUOp,
  input  logic [DATA_W-1:0]  IF_ID_rd1,
  input  logic [DATA_W-1:0]  IF_ID_rd2,
  input  logic [DATA_W-1:0]  IF_ID_imm,
  input  logic [DATA_W-1:0]  IF_ID_pc2,
  output logic [REG_W-1:0]   ID_EX_Rs,
  output logic [REG_W-1:0]   ID_EX_Rt,
  output logic [REG_W-1:0]   ID_EX_Rd,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [DATA_W-1:0]  ID_EX_rd1,
  output logic [DATA_W-1:0]  ID_EX_rd2,
  output logic [DATA_W-1:0]  ID_EX_imm,
  output logic [DATA_W-1:0]  ID_EX_pc2,
  output logic               stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  id_ex_t           id_in;
  id_ex_t           id_ex_d, id_ex_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  upd_e             upd;
  logic             hz;

  load_use_detect u_load_use_detect (
    .ex_mem_read (id_ex_q.ctrl.MemRead),
    .ex_rd       (id_ex_q.rd),
    .id_rs       (IF_ID_Rs),
    .id_rt       (IF_ID_Rt),
    .id_uses_rs  (IF_ID_uses_rs),
    .id_uses_rt  (IF_ID_uses_rt),
    .id_is_store (IF_ID_is_store),
    .hz          (hz)
  );

  // Gather the decoded ID instruction into one register word.
  always_comb begin
    id_in               = ID_EX_BUBBLE;
    id_in.rs            = IF_ID_Rs;
    id_in.rt            = IF_ID_Rt;
    id_in.rd            = IF_ID_Rd;
    id_in.ctrl.RegWrite = IF_ID_RegWrite;
    id_in.ctrl.MemRead  = IF_ID_MemRead;
    id_in.ctrl.MemWrite = IF_ID_MemWrite;
    id_in.ctrl.MemtoReg = IF_ID_MemtoReg;
    id_in.ctrl.ALUSrc   = IF_ID_ALUSrc;
    id_in.ctrl.ALUOp    = IF_ID_ALUOp;
    id_in.rd1           = IF_ID_rd1;
    id_in.rd2           = IF_ID_rd2;
    id_in.imm           = IF_ID_imm;
    id_in.pc2           = IF_ID_pc2;
  end

  // Pick the update source: freeze beats flush beats a load-use bubble.
  always_comb begin
    upd = UPD_LOAD;
    if (freeze)     upd = UPD_HOLD;
    else if (flush) upd = UPD_FLUSH;
    else if (hz)    upd = UPD_HAZARD;
  end

  // Next register contents; only load-use bubbles advance the counter.
  always_comb begin
    id_ex_d      = id_ex_q;
    bubble_cnt_d = bubble_cnt_q;
    unique case (upd)
      UPD_HOLD:   id_ex_d = id_ex_q;
      UPD_FLUSH:  id_ex_d = ID_EX_BUBBLE;
      UPD_HAZARD: begin
        id_ex_d      = ID_EX_BUBBLE;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      UPD_LOAD:   id_ex_d = id_in;
      default:    id_ex_d = id_ex_q;
    endcase
  end

  // Pipeline register and counter; reset overrides freeze and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q      <= ID_EX_BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      id_ex_q      <= id_ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Stall PC and IF/ID only when the bubble will actually be inserted.
  always_comb begin
    stall = hz && !flush && !freeze;
  end

  // Drive EX-facing outputs from the register.
  always_comb begin
    ID_EX_Rs       = id_ex_q.rs;
    ID_EX_Rt       = id_ex_q.rt;
    ID_EX_Rd       = id_ex_q.rd;
    ID_EX_RegWrite = id_ex_q.ctrl.RegWrite;
    ID_EX_MemRead  = id_ex_q.ctrl.MemRead;
    ID_EX_MemWrite = id_ex_q.ctrl.MemWrite;
    ID_EX_MemtoReg = id_ex_q.ctrl.MemtoReg;
    ID_EX_ALUSrc   = id_ex_q.ctrl.ALUSrc;
    ID_EX_ALUOp    = id_ex_q.ctrl.ALUOp;
    ID_EX_rd1      = id_ex_q.rd1;
    ID_EX_rd2      = id_ex_q.rd2;
    ID_EX_imm      = id_ex_q.imm;
    ID_EX_pc2      = id_ex_q.pc2;
    bubble_cnt     = bubble_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed load-use scenarios plus
// randomized traffic against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
  logic        IF_ID_uses_rs, IF_ID_uses_rt, IF_ID_is_store;
  logic        IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_MemtoReg, IF_ID_ALUSrc;
  logic [3:0]  IF_ID_ALUOp;
  logic [15:0] IF_ID_rd1, IF_ID_rd2, IF_ID_imm, IF_ID_pc2;
  logic [3:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc;
  logic [3:0]  ID_EX_ALUOp;
  logic [15:0] ID_EX_rd1, ID_EX_rd2, ID_EX_imm, ID_EX_pc2;
  logic        stall;
  logic [15:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd),
    .IF_ID_uses_rs(IF_ID_uses_rs), .IF_ID_uses_rt(IF_ID_uses_rt), .IF_ID_is_store(IF_ID_is_store),
    .IF_ID_RegWrite(IF_ID_RegWrite), .IF_ID_MemRead(IF_ID_MemRead), .IF_ID_MemWrite(IF_ID_MemWrite),
    .IF_ID_MemtoReg(IF_ID_MemtoReg), .IF_ID_ALUSrc(IF_ID_ALUSrc), .IF_ID_ALUOp(IF_ID_ALUOp),
    .IF_ID_rd1(IF_ID_rd1), .IF_ID_rd2(IF_ID_rd2), .IF_ID_imm(IF_ID_imm), .IF_ID_pc2(IF_ID_pc2),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_rd1(ID_EX_rd1), .ID_EX_rd2(ID_EX_rd2), .ID_EX_imm(ID_EX_imm), .ID_EX_pc2(ID_EX_pc2),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  // One decoded instruction as seen in ID.
  typedef struct packed {
    logic [3:0]  rs, rt, rd;
    logic        uses_rs, uses_rt, is_store;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
    logic [15:0] rd1, rd2, imm, pc2;
  } instr_t;

  // What the DUT should show during one cycle.
  typedef struct packed {
    instr_t      ex;
    logic [15:0] cnt;
    logic        stall;
  } exp_t;

  exp_t        sb[$];
  instr_t      ex_m;          // instruction the model holds in EX
  logic [15:0] cnt_m;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Does instruction `id` consume register r as an ALU operand?
  function automatic bit needs_alu_operand(instr_t id, logic [3:0] r);
    if (r == 4'd0) return 1'b0;
    if (id.uses_rs && id.rs == r) return 1'b1;
    if (id.uses_rt && !id.is_store && id.rt == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic instr_t with_data(instr_t i);
    instr_t o = i;
    o.rd1 = 16'($urandom); o.rd2 = 16'($urandom);
    o.imm = 16'($urandom); o.pc2 = 16'($urandom);
    return o;
  endfunction

  function automatic instr_t lw(logic [3:0] rd, logic [3:0] base);
    instr_t i = '0;
    i.rd = rd; i.rs = base; i.uses_rs = 1'b1;
    i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.as = 1'b1;
    return with_data(i);
  endfunction

  function automatic instr_t add(logic [3:0] rd, logic [3:0] rs, logic [3:0] rt);
    instr_t i = '0;
    i.rd = rd; i.rs = rs; i.rt = rt; i.uses_rs = 1'b1; i.uses_rt = 1'b1;
    i.rw = 1'b1; i.op = 4'd1;
    return with_data(i);
  endfunction

  function automatic instr_t sw(logic [3:0] data_reg, logic [3:0] base);
    instr_t i = '0;
    i.rt = data_reg; i.rs = base; i.uses_rs = 1'b1; i.uses_rt = 1'b1;
    i.is_store = 1'b1; i.mw = 1'b1; i.as = 1'b1;
    return with_data(i);
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = with_data('0);
    i.rs = 4'($urandom_range(0, 3)); i.rt = 4'($urandom_range(0, 3));
    i.rd = 4'($urandom_range(0, 3));
    i.uses_rs = 1'($urandom); i.uses_rt = 1'($urandom); i.is_store = 1'($urandom);
    i.rw = 1'($urandom); i.mr = ($urandom_range(0, 9) < 4);
    i.mw = 1'($urandom); i.m2r = 1'($urandom); i.as = 1'($urandom);
    i.op = 4'($urandom);
    return i;
  endfunction

  // Drive one cycle of ID inputs, record the expected view, advance the model.
  task automatic step(input instr_t id, input logic r, input logic fz, input logic fl);
    exp_t e;
    bit   hz;
    @(posedge clk); #1;
    rst = r; freeze = fz; flush = fl;
    IF_ID_Rs = id.rs; IF_ID_Rt = id.rt; IF_ID_Rd = id.rd;
    IF_ID_uses_rs = id.uses_rs; IF_ID_uses_rt = id.uses_rt; IF_ID_is_store = id.is_store;
    IF_ID_RegWrite = id.rw; IF_ID_MemRead = id.mr; IF_ID_MemWrite = id.mw;
    IF_ID_MemtoReg = id.m2r; IF_ID_ALUSrc = id.as; IF_ID_ALUOp = id.op;
    IF_ID_rd1 = id.rd1; IF_ID_rd2 = id.rd2; IF_ID_imm = id.imm; IF_ID_pc2 = id.pc2;
    hz = ex_m.mr && needs_alu_operand(id, ex_m.rd);
    e.ex = ex_m; e.cnt = cnt_m; e.stall = hz && !fl && !fz;
    sb.push_back(e);
    if (r) begin
      ex_m = '0; cnt_m = 16'd0;
    end else if (fz) begin
      ex_m = ex_m;
    end else if (fl) begin
      ex_m = '0;
    end else if (hz) begin
      ex_m = '0;
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end else begin
      ex_m = id;
      ex_m.uses_rs = 1'b0; ex_m.uses_rt = 1'b0; ex_m.is_store = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a new ID/EX view; compare it.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall", 64'(stall), 64'(e.stall));
      chk("ctrl", 64'({ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_ALUOp}),
          64'({e.ex.rw, e.ex.mr, e.ex.mw, e.ex.m2r, e.ex.as, e.ex.op}));
      chk("regs", 64'({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd}), 64'({e.ex.rs, e.ex.rt, e.ex.rd}));
      chk("data", {ID_EX_rd1, ID_EX_rd2, ID_EX_imm, ID_EX_pc2}, {e.ex.rd1, e.ex.rd2, e.ex.imm, e.ex.pc2});
      chk("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
    end
  end

  initial begin
    instr_t a;
    instr_t nop;
    nop = '0; ex_m = '0; cnt_m = 16'd0;

    // Reset with random inputs for two cycles
    step(rand_instr(), 1'b1, 1'($urandom), 1'($urandom));
    step(rand_instr(), 1'b1, 1'($urandom), 1'($urandom));

    // LW R3 ; ADD R5,R3,R4 (held in IF/ID during stall)
    step(lw(4'd3, 4'd1), 0, 0, 0);
    a = add(4'd5, 4'd3, 4'd4);
    step(a, 0, 0, 0); step(a, 0, 0, 0); step(nop, 0, 0, 0);

    // Store data exempt; store base not exempt
    step(lw(4'd3, 4'd1), 0, 0, 0); step(sw(4'd3, 4'd6), 0, 0, 0); step(nop, 0, 0, 0);
    step(lw(4'd3, 4'd1), 0, 0, 0);
    a = sw(4'd7, 4'd3);
    step(a, 0, 0, 0); step(a, 0, 0, 0); step(nop, 0, 0, 0);

    // R0 and unused operand
    step(lw(4'd0, 4'd1), 0, 0, 0); step(add(4'd1, 4'd0, 4'd0), 0, 0, 0);
    step(lw(4'd2, 4'd1), 0, 0, 0);
    a = add(4'd4, 4'd5, 4'd2); a.uses_rt = 1'b0;
    step(a, 0, 0, 0); step(nop, 0, 0, 0);

    // Flush wins over hazard
    step(lw(4'd3, 4'd1), 0, 0, 0); step(add(4'd5, 4'd3, 4'd4), 0, 0, 1); step(nop, 0, 0, 0);

    // Freeze with a pending hazard and changing inputs
    step(lw(4'd3, 4'd1), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(add(4'd5, 4'd3, 4'($urandom)), 0, 1, 0);
    a = add(4'd5, 4'd3, 4'd4);
    step(a, 0, 0, 0); step(a, 0, 0, 0); step(nop, 0, 0, 0);

    // Reset overrides freeze and flush mid-operation
    step(lw(4'd3, 4'd1), 0, 0, 0); step(add(4'd5, 4'd3, 4'd4), 1, 1, 1); step(nop, 0, 0, 0);

    // Saturation: preload the counter near the top while frozen, then hammer it
    step(nop, 0, 1, 0);
    @(negedge clk); #1;
    force dut.bubble_cnt_q = 16'hFFF0;
    cnt_m = 16'hFFF0;
    step(nop, 0, 1, 0);
    release dut.bubble_cnt_q;
    for (int i = 0; i < 24; i++) begin
      step(lw(4'd3, 4'd1), 0, 0, 0);
      step(add(4'd5, 4'd3, 4'd3), 0, 0, 0);
    end
    step(nop, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(rand_instr(), ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
